// File: rtl/mem_sram_stage_pkg.sv
// Shared types and constants for the MEM stage and its external SRAM controller.
package mem_sram_stage_pkg;

    localparam int REGISTER_LEN      = 32;
    localparam int REG_ADDRESS_LEN   = 4;
    localparam int ADDR_BASE_DEFAULT = 1024;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD_LO = 3'd1;
    localparam logic [2:0] ST_RD_HI = 3'd2;
    localparam logic [2:0] ST_WR_LO = 3'd3;
    localparam logic [2:0] ST_WR_HI = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_RD_LO = ST_RD_LO,
        S_RD_HI = ST_RD_HI,
        S_WR_LO = ST_WR_LO,
        S_WR_HI = ST_WR_HI,
        S_DONE  = ST_DONE
    } state_t;

    // Wait counter never collapses to zero width when WAIT_CYCLES is 0.
    function automatic int cnt_width(input int wait_cycles);
        return (wait_cycles > 0) ? $clog2(wait_cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_sram_stage_if.sv
// Pipeline-side signals of the MEM stage: EXE inputs, WB outputs and the ready handshake.
interface mem_sram_stage_if
    import mem_sram_stage_pkg::*;
#(
    parameter int DATA_W = REGISTER_LEN
) ();

    logic                       wb_en_in;
    logic                       mem_r_en_in;
    logic                       mem_w_en_in;
    logic [DATA_W-1:0]          alu_res_in;
    logic [DATA_W-1:0]          val_Rm;
    logic [REG_ADDRESS_LEN-1:0] dest_in;

    logic                       wb_en_out;
    logic                       mem_r_en_out;
    logic [DATA_W-1:0]          alu_res_out;
    logic [REG_ADDRESS_LEN-1:0] dest_out;
    logic [DATA_W-1:0]          mem_out;
    logic                       ready;

    modport master (
        output wb_en_in, mem_r_en_in, mem_w_en_in, alu_res_in, val_Rm, dest_in,
        input  wb_en_out, mem_r_en_out, alu_res_out, dest_out, mem_out, ready
    );

    modport slave (
        input  wb_en_in, mem_r_en_in, mem_w_en_in, alu_res_in, val_Rm, dest_in,
        output wb_en_out, mem_r_en_out, alu_res_out, dest_out, mem_out, ready
    );

endinterface

// File: rtl/mem_sram_stage_sram_ctrl.sv
// Two-phase (low/high halfword) controller for the external asynchronous SRAM,
// with per-phase wait counting, write-data drive and read capture registers.
module mem_sram_stage_sram_ctrl
    import mem_sram_stage_pkg::*;
#(
    parameter int DATA_W      = REGISTER_LEN,
    parameter int SRAM_DQ_W   = 16,
    parameter int SRAM_ADDR_W = 18,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    input  logic                   wr,
    input  logic [SRAM_ADDR_W-2:0] word,
    input  logic [DATA_W-1:0]      wdata,
    input  logic                   hit_load,
    input  logic [DATA_W-1:0]      hit_data,
    input  logic [SRAM_DQ_W-1:0]   dq_in,
    output logic [SRAM_DQ_W-1:0]   dq_out,
    output logic                   dq_oe,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic                   we_n,
    output logic                   oe_n,
    output logic                   done,
    output logic [DATA_W-1:0]      mem_out
);

    localparam int             CNT_W    = cnt_width(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     wait_cnt_reg, wait_cnt_next;
    logic [SRAM_DQ_W-1:0] low_reg;
    logic [DATA_W-1:0]    mem_out_reg;
    logic                 last, in_phase, is_wr, is_hi;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= S_IDLE;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        last          = (wait_cnt_reg == CNT_LAST);
        in_phase      = 1'b0;
        is_wr         = 1'b0;
        is_hi         = 1'b0;
        case (state_reg)
            S_IDLE:  if (req) state_next = wr ? S_WR_LO : S_RD_LO;
            S_RD_LO: begin
                in_phase = 1'b1;
                if (last) state_next = S_RD_HI;
            end
            S_RD_HI: begin
                in_phase = 1'b1;
                is_hi    = 1'b1;
                if (last) state_next = S_DONE;
            end
            S_WR_LO: begin
                in_phase = 1'b1;
                is_wr    = 1'b1;
                if (last) state_next = S_WR_HI;
            end
            S_WR_HI: begin
                in_phase = 1'b1;
                is_wr    = 1'b1;
                is_hi    = 1'b1;
                if (last) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        // Counter restarts from zero on every phase entry and idles at zero.
        wait_cnt_next = (in_phase && !last) ? wait_cnt_reg + CNT_W'(1) : '0;
    end

    always_comb begin
        sram_addr = '0;
        if (in_phase) sram_addr = {word, is_hi};
        dq_oe  = is_wr;
        dq_out = is_hi ? wdata[DATA_W-1 -: SRAM_DQ_W] : wdata[SRAM_DQ_W-1:0];
        // WE_N releases one cycle before the phase ends so address/data are held past the strobe.
        we_n   = ~(is_wr & ~last);
        oe_n   = is_wr;
        done   = (state_reg == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            low_reg     <= '0;
            mem_out_reg <= '0;
        end else begin
            if (state_reg == S_RD_LO && last) low_reg <= dq_in;
            if (state_reg == S_RD_HI && last) mem_out_reg <= DATA_W'({dq_in, low_reg});
            else if (hit_load)                mem_out_reg <= hit_data;
        end
    end

    assign mem_out = mem_out_reg;

endmodule

// File: rtl/mem_sram_stage.sv
// Pipeline MEM stage driving the board's external async SRAM; stalls via ready.
// Optional single-entry read cache enabled by defining MEM_READ_CACHE_EN.
module mem_sram_stage
    import mem_sram_stage_pkg::*;
#(
    parameter int DATA_W      = REGISTER_LEN,
    parameter int SRAM_DQ_W   = 16,
    parameter int SRAM_ADDR_W = 18,
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_BASE   = ADDR_BASE_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_sram_stage_if.slave        bus,
    inout  wire [SRAM_DQ_W-1:0]    SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_OE_N
);

    localparam int WORD_W = SRAM_ADDR_W - 1;

    logic [DATA_W-1:0]    offset;
    logic [WORD_W-1:0]    word;
    logic                 req, ctrl_req, hit, done, dq_oe, ctrl_oe_n;
    logic [DATA_W-1:0]    hit_data, mem_out;
    logic [SRAM_DQ_W-1:0] dq_out;

    // Truncation of the word index makes accesses wrap modulo the SRAM size.
    assign offset = bus.alu_res_in - DATA_W'(ADDR_BASE);
    assign word   = WORD_W'(offset >> 2);

    assign req      = bus.mem_r_en_in | bus.mem_w_en_in;
    assign ctrl_req = req & ~hit;

    assign bus.wb_en_out    = bus.wb_en_in;
    assign bus.mem_r_en_out = bus.mem_r_en_in;
    assign bus.alu_res_out  = bus.alu_res_in;
    assign bus.dest_out     = bus.dest_in;
    assign bus.mem_out      = mem_out;
    assign bus.ready        = ~req | done | hit;

    assign SRAM_CE_N = ~rst;
    assign SRAM_UB_N = ~rst;
    assign SRAM_LB_N = ~rst;
    assign SRAM_OE_N = ~rst | ctrl_oe_n;
    assign SRAM_DQ   = dq_oe ? dq_out : {SRAM_DQ_W{1'bz}};

    mem_sram_stage_sram_ctrl #(
        .DATA_W      (DATA_W),
        .SRAM_DQ_W   (SRAM_DQ_W),
        .SRAM_ADDR_W (SRAM_ADDR_W),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_sram_ctrl (
        .clk       (clk),
        .rst       (rst),
        .req       (ctrl_req),
        .wr        (bus.mem_w_en_in),
        .word      (word),
        .wdata     (bus.val_Rm),
        .hit_load  (hit),
        .hit_data  (hit_data),
        .dq_in     (SRAM_DQ),
        .dq_out    (dq_out),
        .dq_oe     (dq_oe),
        .sram_addr (SRAM_ADDR),
        .we_n      (SRAM_WE_N),
        .oe_n      (ctrl_oe_n),
        .done      (done),
        .mem_out   (mem_out)
    );

`ifdef MEM_READ_CACHE_EN
    logic              cache_valid_reg;
    logic [WORD_W-1:0] cache_tag_reg;
    logic [DATA_W-1:0] cache_data_reg;

    // Inputs are held while a miss is in flight, so a hit can only appear in IDLE.
    assign hit      = bus.mem_r_en_in & ~bus.mem_w_en_in & cache_valid_reg & (cache_tag_reg == word);
    assign hit_data = cache_data_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cache_valid_reg <= 1'b0;
            cache_tag_reg   <= '0;
            cache_data_reg  <= '0;
        end else if (done) begin
            if (bus.mem_w_en_in) begin
                cache_valid_reg <= 1'b1;
                cache_tag_reg   <= word;
                cache_data_reg  <= bus.val_Rm;
            end else if (bus.mem_r_en_in) begin
                cache_valid_reg <= 1'b1;
                cache_tag_reg   <= word;
                cache_data_reg  <= mem_out;
            end
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

endmodule

// File: tb/tb_mem_sram_stage.sv
// Self-checking bench for mem_sram_stage with a behavioural async SRAM and a result scoreboard.
module tb_mem_sram_stage;
    import mem_sram_stage_pkg::*;

    localparam int WAIT     = 1;
    localparam int FULL_LAT = 1 + 2 * (WAIT + 1);
`ifdef MEM_READ_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_sram_stage_if #(.DATA_W(32)) bus ();

    wire  [15:0] SRAM_DQ;
    logic [17:0] SRAM_ADDR;
    logic        ub_n, lb_n, we_n, ce_n, oe_n;

    mem_sram_stage #(
        .DATA_W(32), .SRAM_DQ_W(16), .SRAM_ADDR_W(18), .WAIT_CYCLES(WAIT), .ADDR_BASE(1024)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n)
    );

    logic [15:0] sram [0:262143];
    assign SRAM_DQ = (!ce_n && !oe_n && we_n) ? sram[SRAM_ADDR] : 16'hzzzz;
    always @(posedge clk) if (!ce_n && !we_n) sram[SRAM_ADDR] <= SRAM_DQ;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] ref_mem [int];
    logic [31:0] model_mem_out = '0;
    bit          c_valid = 1'b0;
    int          c_tag = 0;
    logic [31:0] c_data = '0;
    logic [31:0] exp_q [$];
    int          lat_q [$];

    logic [17:0] log_addr [0:39];
    logic [15:0] log_dq   [0:39];
    logic        log_we   [0:39];
    logic        log_oe   [0:39];

    function automatic int word_of(input logic [31:0] addr);
        return int'(((addr - 32'd1024) >> 2) & 32'h1FFFF);
    endfunction

    // Issues one access at posedge+1, follows it to completion, returns with inputs released.
    task automatic access(input logic r, input logic w, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] dest, input logic wb);
        int          wd, lat, e_lat;
        bit          hit, got;
        logic [31:0] e;
        wd  = word_of(addr);
        hit = CACHE_ON && r && !w && c_valid && (c_tag == wd);
        if (w) begin
            ref_mem[wd] = data;
            e = model_mem_out;
            c_valid = 1'b1; c_tag = wd; c_data = data;
        end else begin
            e = ref_mem.exists(wd) ? ref_mem[wd] : 32'h0;
            model_mem_out = e;
            if (!hit) begin c_valid = 1'b1; c_tag = wd; c_data = e; end
        end
        exp_q.push_back(e);
        lat_q.push_back(hit ? 0 : FULL_LAT);

        bus.mem_r_en_in = r; bus.mem_w_en_in = w; bus.alu_res_in = addr;
        bus.val_Rm = data;   bus.dest_in = dest;  bus.wb_en_in = wb;
        lat = 0; got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            log_addr[c] = SRAM_ADDR; log_dq[c] = SRAM_DQ; log_we[c] = we_n; log_oe[c] = oe_n;
            if (c == 0) begin
                n_vec++;
                if (bus.alu_res_out !== addr || bus.dest_out !== dest ||
                    bus.wb_en_out !== wb || bus.mem_r_en_out !== r) begin
                    n_err++;
                    $display("FAIL passthrough: got alu=%h dest=%h wb=%b r=%b expected alu=%h dest=%h wb=%b r=%b",
                             bus.alu_res_out, bus.dest_out, bus.wb_en_out, bus.mem_r_en_out, addr, dest, wb, r);
                end
            end
            if (bus.ready) got = 1'b1;
            else lat++;
        end
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL ready_timeout: got no ready within 40 cycles, expected ready after %0d", lat_q[0]);
        end
        @(posedge clk); #1;
        e_lat = lat_q.pop_front();
        e     = exp_q.pop_front();
        n_vec++;
        if (lat != e_lat) begin
            n_err++;
            $display("FAIL latency @%h: got %0d low cycles expected %0d", addr, lat, e_lat);
        end
        n_vec++;
        if (bus.mem_out !== e) begin
            n_err++;
            $display("FAIL mem_out @%h: got %h expected %h", addr, bus.mem_out, e);
        end
        $display("txn r=%b w=%b addr=%h data=%h low_cycles=%0d mem_out=%h", r, w, addr, data, lat, bus.mem_out);
        bus.mem_r_en_in = 1'b0; bus.mem_w_en_in = 1'b0; bus.wb_en_in = 1'b0;
    endtask

    task automatic test_reset();
        bus.mem_r_en_in = 1'b0; bus.mem_w_en_in = 1'b0; bus.wb_en_in = 1'b0;
        bus.alu_res_in = '0; bus.val_Rm = '0; bus.dest_in = '0;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (we_n !== 1'b1 || oe_n !== 1'b1 || ce_n !== 1'b1 || SRAM_ADDR !== 18'h0 || bus.mem_out !== 32'h0) begin
            n_err++;
            $display("FAIL reset_state: got we=%b oe=%b ce=%b addr=%h mem_out=%h expected 1 1 1 0 0",
                     we_n, oe_n, ce_n, SRAM_ADDR, bus.mem_out);
        end
        rst = 1'b1;
        $display("txn reset released");
    endtask

    task automatic test_idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (bus.ready !== 1'b1 || we_n !== 1'b1 || oe_n !== 1'b0 || ce_n !== 1'b0 ||
                ub_n !== 1'b0 || lb_n !== 1'b0 || SRAM_ADDR !== 18'h0) begin
                n_err++;
                $display("FAIL idle: got ready=%b we=%b oe=%b ce=%b ub=%b lb=%b addr=%h expected 1 1 0 0 0 0 0",
                         bus.ready, we_n, oe_n, ce_n, ub_n, lb_n, SRAM_ADDR);
            end
            $display("txn idle cycle %0d", i);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_store();
        logic [17:0] ea [0:5];
        logic [15:0] ed [0:5];
        logic        ew [0:5];
        logic        eo [0:5];
        ea = '{18'd0, 18'd4, 18'd4, 18'd5, 18'd5, 18'd0};
        ed = '{16'h0, 16'hBEEF, 16'hBEEF, 16'hDEAD, 16'hDEAD, 16'h0};
        ew = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        eo = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 4'd3, 1'b0);
        for (int c = 0; c < 6; c++) begin
            n_vec++;
            if (log_addr[c] !== ea[c] || log_we[c] !== ew[c] || log_oe[c] !== eo[c] ||
                ((c >= 1 && c <= 4) && log_dq[c] !== ed[c])) begin
                n_err++;
                $display("FAIL store_cycle%0d: got addr=%h dq=%h we=%b oe=%b expected addr=%h dq=%h we=%b oe=%b",
                         c, log_addr[c], log_dq[c], log_we[c], log_oe[c], ea[c], ed[c], ew[c], eo[c]);
            end
        end
    endtask

    task automatic test_load();
        access(1'b1, 1'b0, 32'd1032, 32'h0, 4'd7, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (bus.mem_out !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL load_hold: got %h expected deadbeef", bus.mem_out);
        end
    endtask

    task automatic test_cache();
        access(1'b1, 1'b0, 32'd1032, 32'h0, 4'd7, 1'b1);
        access(1'b0, 1'b1, 32'd1032, 32'h00000001, 4'd2, 1'b0);
        access(1'b1, 1'b0, 32'd1032, 32'h0, 4'd2, 1'b1);
    endtask

    task automatic test_reset_mid_write();
        bus.mem_w_en_in = 1'b1; bus.alu_res_in = 32'd1032; bus.val_Rm = 32'hCAFEF00D;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (SRAM_ADDR !== 18'd5 || we_n !== 1'b0) begin
            n_err++;
            $display("FAIL wr_hi_entry: got addr=%h we=%b expected 5 0", SRAM_ADDR, we_n);
        end
        rst = 1'b0;
        bus.mem_w_en_in = 1'b0;
        #1;
        n_vec++;
        if (we_n !== 1'b1 || oe_n !== 1'b1 || ce_n !== 1'b1 || SRAM_ADDR !== 18'h0 || bus.mem_out !== 32'h0) begin
            n_err++;
            $display("FAIL abort_state: got we=%b oe=%b ce=%b addr=%h mem_out=%h expected 1 1 1 0 0",
                     we_n, oe_n, ce_n, SRAM_ADDR, bus.mem_out);
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (sram[4] !== 16'hF00D || sram[5] !== 16'h0000) begin
            n_err++;
            $display("FAIL partial_write: got lo=%h hi=%h expected f00d 0000", sram[4], sram[5]);
        end
        ref_mem[2] = {sram[5], 16'hF00D};
        model_mem_out = '0;
        c_valid = 1'b0;
        $display("txn reset during WR_HI, sram lo=%h hi=%h", sram[4], sram[5]);
        access(1'b1, 1'b0, 32'd1032, 32'h0, 4'd1, 1'b1);
    endtask

    task automatic test_read_write_both();
        access(1'b1, 1'b1, 32'd1040, 32'h12345678, 4'd5, 1'b1);
        access(1'b1, 1'b0, 32'd1040, 32'h0, 4'd5, 1'b1);
    endtask

    task automatic test_wrap();
        access(1'b0, 1'b1, 32'd1020, 32'h0BAD0C0D, 4'd0, 1'b0);
        n_vec++;
        if (log_addr[1] !== 18'h3FFFE || log_addr[3] !== 18'h3FFFF) begin
            n_err++;
            $display("FAIL wrap_addr: got lo=%h hi=%h expected 3fffe 3ffff", log_addr[1], log_addr[3]);
        end
        access(1'b0, 1'b1, 32'd1024 + 32'h80000, 32'hAAAA5555, 4'd0, 1'b0);
        access(1'b1, 1'b0, 32'd1024, 32'h0, 4'd0, 1'b1);
        access(1'b1, 1'b0, 32'd1020, 32'h0, 4'd0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] addr;
        for (int i = 0; i < 4; i++)
            access(1'b0, 1'b1, 32'd1032 + 32'(4 * i), $urandom, 4'(i), 1'b0);
        for (int i = 0; i < 10; i++) begin
            addr = 32'd1032 + 32'(4 * $urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) access(1'b0, 1'b1, addr, $urandom, 4'(i), 1'b0);
            else                           access(1'b1, 1'b0, addr, 32'h0, 4'(i), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_store();
        test_load();
        test_cache();
        test_reset_mid_write();
        test_read_write_both();
        test_wrap();
        test_back_to_back();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_sram_stage.md
Name: mem_sram_stage

Overview:
- Parametrised successor to the pipeline MEM stage.
- Replaces the tied-off SRAM pins and the internal single-cycle memory model with a real multi-cycle controller for the board's external asynchronous SRAM.
- Each 32-bit word access is split into two 16-bit halfword phases, with a programmable wait count per phase.
- A `ready` handshake freezes the pipeline until the access completes.

Parameters:
- DATA_W, 32: pipeline data width; must equal 2*SRAM_DQ_W.
- SRAM_DQ_W, 16: SRAM data bus width.
- SRAM_ADDR_W, 18: SRAM halfword address width.
- WAIT_CYCLES, 1: extra cycles held per halfword phase (phase length = WAIT_CYCLES+1).
- ADDR_BASE, 1024: byte address subtracted from alu_res_in before mapping.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- wb_en_in  in  1  write-back enable from EXE.
- mem_r_en_in  in  1  load request.
- mem_w_en_in  in  1  store request.
- alu_res_in  in  DATA_W  byte address / ALU result.
- val_Rm  in  DATA_W  store data.
- dest_in  in  4  destination register.
- wb_en_out  out  1  = wb_en_in.
- mem_r_en_out  out  1  = mem_r_en_in.
- alu_res_out  out  DATA_W  = alu_res_in.
- dest_out  out  4  = dest_in.
- mem_out  out  DATA_W  registered load data.
- ready  out  1  high when stage can advance.
- SRAM_DQ  inout  SRAM_DQ_W  SRAM data bus.
- SRAM_ADDR  out  SRAM_ADDR_W  halfword address.
- SRAM_UB_N, SRAM_LB_N  out  1  byte masks.
- SRAM_WE_N  out  1  write strobe.
- SRAM_CE_N, SRAM_OE_N  out  1  chip / output enable.

Behaviour:
- Pass-through outputs are combinational.
- Address mapping:
  - word = (alu_res_in - ADDR_BASE) >> 2, truncated to SRAM_ADDR_W-1 bits.
  - Low halfword address = {word,1'b0}; high halfword address = {word,1'b1}.
  - Addresses wrap modulo the SRAM size; there is no error output.
- req = mem_r_en_in | mem_w_en_in. If both are asserted, the access is a write and mem_out is unchanged.
- FSM states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
  - IDLE: req & write -> WR_LO; req & read -> RD_LO; otherwise stay in IDLE.
  - Each phase state holds for WAIT_CYCLES+1 cycles, counted by wait_cnt (width clog2(WAIT_CYCLES+1), cleared on every phase entry).
  - RD_LO -> RD_HI; WR_LO -> WR_HI.
  - RD_HI and WR_HI -> DONE.
  - DONE -> IDLE unconditionally.
- ready = ~req | (state==DONE), combinational.
  - Upstream holds all inputs stable while ready=0.
  - The pipeline advances on the DONE edge.
  - The next request is seen in IDLE, so back-to-back accesses have one IDLE cycle between them.
- Latency: ready stays low for 1 + 2*(WAIT_CYCLES+1) cycles, then is high for the DONE cycle. With default parameters this is 5 low cycles.
- Read capture:
  - On the last cycle of RD_LO, SRAM_DQ is latched into the low holding register.
  - On the last cycle of RD_HI, mem_out <= {SRAM_DQ, low}, so mem_out is valid in DONE.
  - mem_out then holds until the next read.
- Write drive:
  - In WR_LO, SRAM_DQ = val_Rm[15:0]; in WR_HI, SRAM_DQ = val_Rm[31:16].
  - SRAM_WE_N = 0 in every WR_* cycle except the last cycle of each phase, giving address/data hold.
  - SRAM_DQ is high-Z in all other states.
- Fixed SRAM controls:
  - SRAM_UB_N = SRAM_LB_N = 0 and SRAM_CE_N = 0 whenever out of reset.
  - SRAM_OE_N = 0 except in WR_* states.
  - SRAM_ADDR = 0 in IDLE and DONE.
- Reset (async, active-low):
  - state = IDLE, wait_cnt = 0, mem_out = 0, low register = 0.
  - SRAM_WE_N = 1, SRAM_OE_N = 1, SRAM_CE_N = 1, SRAM_DQ = Z, SRAM_ADDR = 0.
  - Reset mid-access aborts immediately; a partial write (low half only) is permitted.

Optional Feature:
- MEM_READ_CACHE_EN: single-entry last-word cache holding tag (word address), data and a valid bit.
- With the macro defined:
  - A read hit in IDLE gives ready=1 the same cycle and mem_out <= cached data on that edge (hit path registered through mem_out, one cycle).
  - A read miss fills the entry at DONE.
  - Any write updates the entry if it matches the tag, or takes over the entry (tag and data) if it does not.
  - Reset clears valid.
- Without the macro: every read runs the full FSM; no cache storage.

Decomposition:
- Shared package/defines: REGISTER_LEN, REG_ADDRESS_LEN, state encoding localparams, ADDR_BASE default.
- One natural sub-module: sram_ctrl, containing the FSM, wait counter, DQ tri-state and capture registers. mem_sram_stage wraps it with the pass-throughs and the optional cache.

Test Plan:
- Idle, no request -> ready=1 every cycle, SRAM_WE_N=1, SRAM_DQ=Z, SRAM_ADDR=0.
- Store val_Rm=0xDEADBEEF at alu_res_in=1032 -> SRAM_ADDR=4 with DQ=0xBEEF, then SRAM_ADDR=5 with DQ=0xDEAD; WE_N low for 1 cycle per phase; ready low for 5 cycles, high on the 6th.
- Load from 1032 after the above store -> ready low for 5 cycles; mem_out=0xDEADBEEF in DONE and held afterwards; wb_en_out and dest_out pass through unchanged.
- Assert rst=0 during WR_HI -> next cycle state=IDLE, WE_N=1, DQ=Z, mem_out=0; SRAM word 1032 has low half new, high half old.
- mem_r_en_in=mem_w_en_in=1 with val_Rm=0x12345678 -> write sequence performed; mem_out unchanged.
- MEM_READ_CACHE_EN: load 1032 twice -> second load has ready=1 in the same cycle with mem_out=0xDEADBEEF; a store to 1032 of 0x1 followed by a load -> hit returns 0x1.
